// File: rtl/eth_mem_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : eth_mem_stream_ctrl
// Purpose  : Bridges the host AXI-Stream Ethernet ports to the processor /
//            top-level memory banks. Decodes the host command word and
//            streams BURST 64-bit words into (opcode 1) or out of (opcode 2)
//            the selected memory, reporting busy/done/err/beat count.
// Options  : define ETH_TLAST_CHECK_EN to flag tlast-position mismatches on
//            write bursts in status.err (termination rules are unchanged).
// Revision : 1.0 - initial release
// ============================================================================
module eth_mem_stream_ctrl #(
  parameter int BURST      = 128,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] command,
  output logic [31:0] status,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic [7:0]  m_axis_tstrb,
  input  logic        m_axis_tready,
  output logic [2:0]  mem_proc_sel,
  output logic [3:0]  mem_sel,
  output logic [10:0] mem_addr,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic        mem_re,
  input  logic [63:0] mem_rdata
);

  // Counters must be able to hold BURST itself (the final count is reported).
  localparam int CNT_W = $clog2(BURST + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough for FIFO occupancy plus every read still in the pipe.
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

  localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BURST - 1);
  localparam logic [CNT_W-1:0] BEAT_TOTAL = CNT_W'(BURST);
  localparam logic [OCC_W-1:0] OCC_LIMIT  = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [7:0]       OP_NONE    = 8'h00;
  localparam logic [7:0]       OP_WRITE   = 8'h01;
  localparam logic [7:0]       OP_READ    = 8'h02;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [10:0]      base_addr;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] rd_issue_cnt;
  logic             done;
  logic             err;

  // Read-return tracking and output skid FIFO
  logic [RD_LAT-1:0] rd_pipe;
  logic [63:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  fifo_cnt;
  logic [OCC_W-1:0]  inflight;

  logic [7:0] opcode;
  logic       start;
  logic       wr_beat;
  logic       wr_end;
  logic       rd_pop;
  logic       rd_push;
  logic       fifo_empty;
  logic [7:0] beat_cnt_byte;
  logic       unused_cmd_bits;

  assign opcode          = command[31:24];
  assign unused_cmd_bits = ^{command[23], command[15:11]};
  assign start           = (state == IDLE) && ((opcode == OP_WRITE) || (opcode == OP_READ));

  // Write path: every accepted beat is written straight through to memory.
  assign s_axis_tready = (state == WR);
  assign wr_beat       = (state == WR) && s_axis_tvalid;
  assign wr_end        = wr_beat && (s_axis_tlast || (beat_cnt == BEAT_LAST));
  assign mem_we        = wr_beat && !rst;
  assign mem_wdata     = mem_we ? s_axis_tdata : 64'd0;

  // Read path: the FIFO head is presented on the outbound stream.
  assign fifo_empty    = (fifo_cnt == '0);
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? 64'd0 : fifo_mem[rd_ptr];
  assign m_axis_tlast  = !fifo_empty && (beat_cnt == BEAT_LAST);
  assign m_axis_tstrb  = 8'hFF;
  assign rd_pop        = (state == RD) && m_axis_tvalid && m_axis_tready;
  assign rd_push       = rd_pipe[RD_LAT-1];

  // Count reads issued but not yet landed in the FIFO
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OCC_W'(rd_pipe[i]);
    end
  end

  // A read is only issued when its data is guaranteed a FIFO slot on return,
  // so backpressure on the outbound stream can never overflow the FIFO.
  assign mem_re = (state == RD) && !rst && (rd_issue_cnt < BEAT_TOTAL)
                  && ((fifo_cnt + inflight) < OCC_LIMIT);

  // Word address: writes follow the accepted-beat count, reads the issue count
  always_comb begin
    mem_addr = 11'd0;
    if (state == WR) begin
      mem_addr = base_addr + 11'(beat_cnt);
    end else if (state == RD) begin
      mem_addr = base_addr + 11'(rd_issue_cnt);
    end
  end

  assign beat_cnt_byte = 8'(beat_cnt);
  assign status = {((state == WR) || (state == RD)), done, err, 21'd0, beat_cnt_byte};

  // Command FSM: capture, burst sequencing and completion handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      base_addr    <= 11'd0;
      mem_proc_sel <= 3'd0;
      mem_sel      <= 4'd0;
      beat_cnt     <= '0;
      rd_issue_cnt <= '0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mem_proc_sel <= command[22:20];
            mem_sel      <= command[19:16];
            base_addr    <= command[10:0];
            beat_cnt     <= '0;
            rd_issue_cnt <= '0;
            done         <= 1'b0;
            state        <= (opcode == OP_WRITE) ? WR : RD;
          end
        end
        WR: begin
          if (wr_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (wr_end) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        RD: begin
          if (mem_re) begin
            rd_issue_cnt <= rd_issue_cnt + 1'b1;
          end
          if (rd_pop) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BEAT_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          // Wait for the host to clear the opcode so a held command cannot re-trigger
          if (opcode == OP_NONE) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency pipe, FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      rd_pipe[0] <= mem_re;
      if (rd_push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({rd_push, rd_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage captures returned read data
  always_ff @(posedge clk) begin
    if (rd_push) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

`ifdef ETH_TLAST_CHECK_EN
  // Flag a write beat whose tlast disagrees with being beat BURST-1
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start) begin
      err <= 1'b0;
    end else if (wr_beat && (s_axis_tlast != (beat_cnt == BEAT_LAST))) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_mem_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_mem_stream_ctrl
// Purpose  : Self-checking bench for eth_mem_stream_ctrl. Random write/read
//            bursts are compared against a word-addressed reference memory
//            and the burst rules (beat count, wrap, tlast, backpressure).
// Options  : honours ETH_TLAST_CHECK_EN for the expected err flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_mem_stream_ctrl;

  localparam int BURST      = 128;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;
`ifdef ETH_TLAST_CHECK_EN
  localparam bit TLAST_CHK = 1'b1;
`else
  localparam bit TLAST_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] command;
  logic [31:0] status;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tstrb;
  logic        m_axis_tready;
  logic [2:0]  mem_proc_sel;
  logic [3:0]  mem_sel;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic        mem_re;
  logic [63:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt, re_cnt, rdy_cnt, busy_cnt;

  // Memory as seen by the DUT, and what the bench expects it to contain
  logic [63:0] tb_mem  [2048];
  logic [63:0] ref_mem [2048];
  logic [63:0] rd_ret  [RD_LAT];

  always #5 clk = ~clk;

  eth_mem_stream_ctrl #(
    .BURST      (BURST),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .command       (command),
    .status        (status),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tready (m_axis_tready),
    .mem_proc_sel  (mem_proc_sel),
    .mem_sel       (mem_sel),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata)
  );

  // Synchronous memory with RD_LAT cycles of read latency
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    rd_ret[0] <= mem_re ? tb_mem[mem_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) rd_ret[i] <= rd_ret[i-1];
  end
  assign mem_rdata = rd_ret[RD_LAT-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    command       = 32'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("idle_busy", status[31], 1'b0);
  endtask

  // One write burst; last_pos is the beat carrying tlast (>= BURST: never)
  task automatic run_write(input logic [10:0] base, input logic [2:0] ps, input logic [3:0] ms,
                           input int last_pos, input bit gaps);
    logic [63:0] dat [BURST];
    int  n, k, writes, first_we, last_we, tail, we_mis, rdy_late;
    bit  done_seen, exp_err;
    n       = (last_pos < BURST) ? last_pos + 1 : BURST;
    exp_err = TLAST_CHK && (last_pos != BURST - 1);
    for (int i = 0; i < BURST; i++) dat[i] = {$urandom, $urandom};
    @(negedge clk);
    command       = {8'h01, 1'b0, ps, ms, 5'd0, base};
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("wr_busy", status[31], 1'b1);
    check_eq("wr_done_clr", status[30], 1'b0);
    check_eq("wr_sel", {mem_proc_sel, mem_sel}, {ps, ms});
    k = 0; writes = 0; first_we = -1; last_we = -1; tail = 0; we_mis = 0; rdy_late = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 8 * BURST && tail < 4; cyc++) begin
      @(negedge clk);
      s_axis_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_axis_tdata  = dat[(k < BURST) ? k : 0];
      s_axis_tlast  = (k == last_pos);
      #1;
      if (mem_we != (s_axis_tvalid && s_axis_tready)) we_mis++;
      if (done_seen && s_axis_tready) rdy_late++;
      if (mem_we) begin
        writes++;
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
        if (k < n) begin
          check_eq("wr_addr", mem_addr, 11'(base + k));
          check_eq("wr_data", mem_wdata, dat[k]);
          ref_mem[11'(base + k)] = dat[k];
        end
      end
      if (s_axis_tvalid && s_axis_tready) k++;
      if (status[30]) done_seen = 1'b1;
      if (done_seen) tail++;
    end
    s_axis_tvalid = 1'b0;
    check_eq("wr_done_seen", done_seen, 1'b1);
    check_eq("wr_count", writes, n);
    check_eq("wr_accepted", k, n);
    check_eq("wr_we_match", we_mis, 0);
    check_eq("wr_ready_after_end", rdy_late, 0);
    if (!gaps) check_eq("wr_consecutive", last_we - first_we, n - 1);
    check_eq("wr_status", status, {1'b0, 1'b1, exp_err, 21'd0, 8'(n)});
  endtask

  // One read burst; mode 0 = tready high, 1 = toggling, 2 = random.
  // abort_at >= 0 pulses rst once that many beats have been accepted.
  task automatic run_read(input logic [10:0] base, input logic [2:0] ps, input logic [3:0] ms,
                          input int mode, input int abort_at);
    int  k, issued, first_re, first_vld, first_pop, last_pop, over, hold_bad, tail;
    bit  done_seen, prev_stall, prev_last;
    logic [63:0] prev_data;
    k = 0; issued = 0; first_re = -1; first_vld = -1; first_pop = -1; last_pop = -1;
    over = 0; hold_bad = 0; tail = 0; done_seen = 1'b0; prev_stall = 1'b0;
    prev_last = 1'b0; prev_data = 64'd0;
    @(negedge clk);
    command       = {8'h02, 1'b0, ps, ms, 5'd0, base};
    m_axis_tready = 1'b0;
    for (int cyc = 0; cyc < 10 * BURST && tail < 4; cyc++) begin
      @(negedge clk);
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 2 == 0);
        default: m_axis_tready = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata != prev_data || m_axis_tlast != prev_last))
        hold_bad++;
      if (mem_re) begin
        if (first_re < 0) first_re = cyc;
        check_eq("rd_addr", mem_addr, 11'(base + issued));
        issued++;
      end
      if (issued - k > FIFO_DEPTH) over++;
      if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        check_eq("rd_data", m_axis_tdata, ref_mem[11'(base + k)]);
        check_eq("rd_last", m_axis_tlast, (k == BURST - 1));
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        k++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (status[30]) done_seen = 1'b1;
      if (done_seen) tail++;
      if (abort_at >= 0 && k == abort_at) break;
    end
    if (abort_at >= 0) begin
      check_eq("abort_reached", k, abort_at);
      @(negedge clk);
      rst           = 1'b1;
      m_axis_tready = 1'b0;
      command       = 32'd0;
      #1;
      check_eq("abort_re_in_rst", mem_re, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("abort_tvalid", m_axis_tvalid, 1'b0);
      check_eq("abort_re", mem_re, 1'b0);
      check_eq("abort_status", status, 32'd0);
    end else begin
      check_eq("rd_done_seen", done_seen, 1'b1);
      check_eq("rd_beats", k, BURST);
      check_eq("rd_issued", issued, BURST);
      check_eq("rd_fifo_bound", over, 0);
      check_eq("rd_hold_stable", hold_bad, 0);
      check_eq("rd_latency", first_vld - first_re, RD_LAT + 1);
      if (mode == 0) check_eq("rd_throughput", last_pop - first_pop, BURST - 1);
      check_eq("rd_sel", {mem_proc_sel, mem_sel}, {ps, ms});
      check_eq("rd_status", status, {2'b01, 1'b0, 21'd0, 8'(BURST)});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    command       = 32'd0;
    s_axis_tdata  = 64'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    for (int a = 0; a < 2048; a++) begin
      tb_mem[a]  = 64'(a);
      ref_mem[a] = 64'(a);
    end
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_status", status, 32'd0);
    check_eq("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check_eq("rst_m_tdata", m_axis_tdata, 64'd0);
    check_eq("rst_m_tlast", m_axis_tlast, 1'b0);
    check_eq("rst_m_tstrb", m_axis_tstrb, 8'hFF);
    check_eq("rst_s_tready", s_axis_tready, 1'b0);
    check_eq("rst_mem_strobes", {mem_we, mem_re}, 2'b00);
    check_eq("rst_mem_addr", mem_addr, 11'd0);
    check_eq("rst_mem_wdata", mem_wdata, 64'd0);
    check_eq("rst_mem_sel", {mem_proc_sel, mem_sel}, 7'd0);
    @(negedge clk);
    rst = 1'b0;

    // Read with toggling backpressure: data equals address 0..127
    run_read(11'h000, 3'd0, 4'd4, 1, -1);
    go_idle();

    // Full write burst, continuous tvalid, tlast on beat 127
    run_write(11'h100, 3'd4, 4'd2, BURST - 1, 1'b0);

    // Command held after completion must not start a second burst
    we_cnt = 0; rdy_cnt = 0; busy_cnt = 0;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      we_cnt   += int'(mem_we);
      rdy_cnt  += int'(s_axis_tready);
      busy_cnt += int'(status[31]);
    end
    check_eq("held_no_writes", we_cnt, 0);
    check_eq("held_no_ready", rdy_cnt, 0);
    check_eq("held_flags", {busy_cnt, status[31:30]}, {32'd0, 2'b01});
    @(negedge clk);
    command       = 32'd0;
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("cleared_flags", status[31:30], 2'b01);

    // Unsupported opcode is ignored
    @(negedge clk);
    command = 32'h0300_0000;
    we_cnt = 0; re_cnt = 0; busy_cnt = 0; rdy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      we_cnt   += int'(mem_we);
      re_cnt   += int'(mem_re);
      rdy_cnt  += int'(s_axis_tready);
      busy_cnt += int'(status[31]);
    end
    check_eq("op3_activity", {we_cnt[15:0], re_cnt[15:0], rdy_cnt[15:0], busy_cnt[15:0]}, 64'd0);
    go_idle();

    // Address wrap with random tvalid gaps
    run_write(11'h7C0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), BURST - 1, 1'b1);
    go_idle();

    // Early tlast on beat 9
    run_write(11'($urandom), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 9, 1'b0);
    go_idle();

    // Burst that reaches beat BURST-1 without tlast
    run_write(11'($urandom), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1000, 1'b1);
    go_idle();

    // Read back the wrapped region under random backpressure
    run_read(11'h7C0, 3'd1, 4'd7, 2, -1);
    go_idle();

    // Reset mid-read, then a fresh read must start from beat 0
    run_read(11'h100, 3'd2, 4'd3, 0, 50);
    run_read(11'h100, 3'd2, 4'd3, 2, -1);
    go_idle();

    // Random base at full throughput
    run_read(11'($urandom), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 0, -1);
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
